// File: rtl/harness_pkg.sv
// harness_pkg
//   Shared types and status codes for the packet harness. The packet
//   constructor decodes result_status with the STATUS_* codes below.
//   Ports: none (package).
package harness_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FORWARD   = 3'd1,
      ST_DRAIN     = 3'd2,
      ST_TERMINATE = 3'd3,
      ST_REPORT    = 3'd4
   } ctrl_state_t;

   localparam logic [1:0] STATUS_OK          = 2'd0;
   localparam logic [1:0] STATUS_BAD_CHANNEL = 2'd1;
   localparam logic [1:0] STATUS_EMPTY       = 2'd2;
   localparam logic [1:0] STATUS_TIMEOUT     = 2'd3;

   // Width of a channel index; at least one bit so a single-channel build
   // still has a legal select register.
   function automatic int sel_width(input int channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

endpackage

// File: rtl/saturating_cycle_counter.sv
// saturating_cycle_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clock   system clock
//     reset   synchronous, active-high; clears count
//     clear   synchronous clear (same effect as reset)
//     enable  advance by one when not already saturated
//     count   current count
module saturating_cycle_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   output logic [WIDTH-1:0] count
);

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable && !(&count)) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/multi_channel_processor_controller.sv
// multi_channel_processor_controller
//   Routes one packet at a time from the parsed-packet FIFO to one of
//   CHANNELS processors (selected by the header byte), returns that
//   processor's output on egress, and reports elapsed cycles and a status.
//   Ports:
//     clock, reset                 clock; synchronous active-high reset
//     in_data/valid/ready/last     ingress stream (header beat, then payload)
//     ch_in_data/valid/ready/last  payload to processors, slice k = channel k
//     ch_enable                    one-hot (or zero) processor enable
//     ch_out_data/valid/ready/last processor results, slice k = channel k
//     out_data/valid/ready/last    egress stream
//     result_cycles/status/valid/ready  per-packet report handshake
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   IDLE      | waiting for a header beat
//   FORWARD   | payload/result passthrough to/from channel sel, counting
//   DRAIN     | discarding ingress beats until in_last (bad channel/timeout)
//   TERMINATE | timeout mid-egress: emitting a forced zero last beat
//   REPORT    | holding result_cycles/result_status until result_ready
module multi_channel_processor_controller
   import harness_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int CHANNELS       = 4,
   parameter int COUNTER_WIDTH  = 32,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [DATA_WIDTH-1:0]          in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic                           in_last,
   output logic [CHANNELS*DATA_WIDTH-1:0] ch_in_data,
   output logic [CHANNELS-1:0]            ch_in_valid,
   input  logic [CHANNELS-1:0]            ch_in_ready,
   output logic [CHANNELS-1:0]            ch_in_last,
   output logic [CHANNELS-1:0]            ch_enable,
   input  logic [CHANNELS*DATA_WIDTH-1:0] ch_out_data,
   input  logic [CHANNELS-1:0]            ch_out_valid,
   output logic [CHANNELS-1:0]            ch_out_ready,
   input  logic [CHANNELS-1:0]            ch_out_last,
   output logic [DATA_WIDTH-1:0]          out_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic                           out_last,
   output logic [COUNTER_WIDTH-1:0]       result_cycles,
   output logic [1:0]                     result_status,
   output logic                           result_valid,
   input  logic                           result_ready
);

   localparam int SEL_W = sel_width(CHANNELS);
   // Widened by one bit so CHANNELS = 2**DATA_WIDTH still compares correctly.
   localparam logic [DATA_WIDTH:0]    CH_LIMIT = (DATA_WIDTH+1)'(CHANNELS);
   localparam logic [COUNTER_WIDTH-1:0] TO_CNT = COUNTER_WIDTH'(TIMEOUT_CYCLES);

   ctrl_state_t              state;
   logic [SEL_W-1:0]         sel;
   logic                     in_done;
   logic                     out_done;
   logic                     out_started;
   logic [COUNTER_WIDTH-1:0] count;
   logic [COUNTER_WIDTH-1:0] cnt_plus1;

   logic st_forward;
   logic st_terminate;
   logic bad_channel;
   logic in_acc;
   logic out_acc;
   logic in_fin;
   logic out_fin;
   logic out_started_n;
   logic timeout_hit;

   logic                  sel_in_ready;
   logic                  sel_out_valid;
   logic                  sel_out_last;
   logic [DATA_WIDTH-1:0] sel_out_data;

   assign st_forward   = (state == ST_FORWARD);
   assign st_terminate = (state == ST_TERMINATE);

   saturating_cycle_counter #(
      .WIDTH(COUNTER_WIDTH)
   ) u_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  ((state == ST_IDLE) && in_valid),
      .enable (st_forward),
      .count  (count)
   );

   // Value the counter will hold after this cycle, saturating.
   assign cnt_plus1 = (&count) ? count : count + COUNTER_WIDTH'(1);

   // ---------------------------------------------------------------
   // Per-channel fan-out; unselected channels see everything at zero.
   // Each output is its own assign so processor loopbacks (ready tied
   // to ready, valid to valid) never look like a combinational cycle.
   // ---------------------------------------------------------------
   for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
      logic fwd_k;
      assign fwd_k = st_forward && (sel == SEL_W'(k));
      assign ch_enable[k]    = fwd_k;
      assign ch_in_data[k*DATA_WIDTH +: DATA_WIDTH] = fwd_k ? in_data : '0;
      assign ch_in_valid[k]  = fwd_k && in_valid && !in_done;
      assign ch_in_last[k]   = fwd_k && in_last && !in_done;
      assign ch_out_ready[k] = fwd_k && out_ready && !out_done;
   end

   assign sel_in_ready  = ch_in_ready[sel];
   assign sel_out_valid = ch_out_valid[sel];
   assign sel_out_last  = ch_out_last[sel];
   assign sel_out_data  = ch_out_data[sel*DATA_WIDTH +: DATA_WIDTH];

   // in_ready is forced low while reset is held so every output reads 0
   // during reset, not just after it.
   always_comb begin
      in_ready = 1'b0;
      if (!reset) begin
         case (state)
            ST_IDLE, ST_DRAIN: in_ready = 1'b1;
            ST_FORWARD:        in_ready = sel_in_ready && !in_done;
            default:           in_ready = 1'b0;
         endcase
      end
   end

   always_comb begin
      out_valid = 1'b0;
      out_last  = 1'b0;
      out_data  = '0;
      if (st_forward && !out_done) begin
         out_valid = sel_out_valid;
         out_last  = sel_out_last;
         out_data  = sel_out_data;
      end else if (st_terminate) begin
         out_valid = 1'b1;
         out_last  = 1'b1;
      end
   end

   assign result_valid = (state == ST_REPORT);

   assign bad_channel   = ({1'b0, in_data} >= CH_LIMIT);
   assign in_acc        = in_valid && in_ready;
   assign out_acc       = out_valid && out_ready;
   assign in_fin        = in_done || (in_acc && in_last);
   assign out_fin       = out_done || (out_acc && out_last);
   assign out_started_n = out_started || out_acc;
   assign timeout_hit   = (TIMEOUT_CYCLES != 0) && (cnt_plus1 == TO_CNT);

   always_ff @(posedge clock) begin
      if (reset) begin
         state         <= ST_IDLE;
         sel           <= '0;
         in_done       <= 1'b0;
         out_done      <= 1'b0;
         out_started   <= 1'b0;
         result_cycles <= '0;
         result_status <= STATUS_OK;
      end else begin
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  sel           <= in_data[SEL_W-1:0];
                  in_done       <= in_last;
                  out_done      <= 1'b0;
                  out_started   <= 1'b0;
                  result_cycles <= '0;
                  if (bad_channel) begin
                     result_status <= STATUS_BAD_CHANNEL;
                     state         <= in_last ? ST_REPORT : ST_DRAIN;
                  end else if (in_last) begin
                     result_status <= STATUS_EMPTY;
                     state         <= ST_REPORT;
                  end else begin
                     result_status <= STATUS_OK;
                     state         <= ST_FORWARD;
                  end
               end
            end

            ST_FORWARD: begin
               in_done     <= in_fin;
               out_done    <= out_fin;
               out_started <= out_started_n;
               if (in_fin && out_fin) begin
                  result_cycles <= cnt_plus1;
                  result_status <= STATUS_OK;
                  state         <= ST_REPORT;
               end else if (timeout_hit) begin
                  result_cycles <= TO_CNT;
                  result_status <= STATUS_TIMEOUT;
                  // A started but unfinished egress packet must still be
                  // closed with a last beat so downstream framing holds.
                  if (out_started_n && !out_fin) begin
                     state <= ST_TERMINATE;
                  end else if (!in_fin) begin
                     state <= ST_DRAIN;
                  end else begin
                     state <= ST_REPORT;
                  end
               end
            end

            ST_TERMINATE: begin
               if (out_ready) begin
                  state <= in_done ? ST_REPORT : ST_DRAIN;
               end
            end

            ST_DRAIN: begin
               if (in_valid && in_last) begin
                  in_done <= 1'b1;
                  state   <= ST_REPORT;
               end
            end

            ST_REPORT: begin
               if (result_ready) begin
                  state <= ST_IDLE;
               end
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multi_channel_processor_controller.sv
// tb_multi_channel_processor_controller
//   Self-checking bench for multi_channel_processor_controller with
//   CHANNELS=4 and TIMEOUT_CYCLES=16. Processors are modelled as lossless
//   combinational echoes; channel 3 can be switched to "emit one beat then
//   stall" for the timeout scenario.
module tb_multi_channel_processor_controller;

   localparam int DW = 8;
   localparam int CH = 4;
   localparam int CW = 32;
   localparam int TO = 16;

   logic               clock;
   logic               reset;
   logic [DW-1:0]      in_data;
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic [CH*DW-1:0]   ch_in_data;
   logic [CH-1:0]      ch_in_valid;
   logic [CH-1:0]      ch_in_ready;
   logic [CH-1:0]      ch_in_last;
   logic [CH-1:0]      ch_enable;
   logic [CH*DW-1:0]   ch_out_data;
   logic [CH-1:0]      ch_out_valid;
   logic [CH-1:0]      ch_out_ready;
   logic [CH-1:0]      ch_out_last;
   logic [DW-1:0]      out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic [CW-1:0]      result_cycles;
   logic [1:0]         result_status;
   logic               result_valid;
   logic               result_ready;

   int total;
   int passed;

   logic stall_mode;
   int   emitted;

   multi_channel_processor_controller #(
      .DATA_WIDTH     (DW),
      .CHANNELS       (CH),
      .COUNTER_WIDTH  (CW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .in_data       (in_data),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_last       (in_last),
      .ch_in_data    (ch_in_data),
      .ch_in_valid   (ch_in_valid),
      .ch_in_ready   (ch_in_ready),
      .ch_in_last    (ch_in_last),
      .ch_enable     (ch_enable),
      .ch_out_data   (ch_out_data),
      .ch_out_valid  (ch_out_valid),
      .ch_out_ready  (ch_out_ready),
      .ch_out_last   (ch_out_last),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_last      (out_last),
      .result_cycles (result_cycles),
      .result_status (result_status),
      .result_valid  (result_valid),
      .result_ready  (result_ready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Processor models: echo input straight back to output.
   always_comb begin
      ch_out_data = ch_in_data;
   end
   always_comb begin
      ch_out_last = ch_in_last;
      if (stall_mode) ch_out_last[3] = 1'b0;
   end
   always_comb begin
      ch_out_valid = ch_in_valid;
      if (stall_mode) ch_out_valid[3] = ch_in_valid[3] && (emitted == 0);
   end
   always_comb begin
      ch_in_ready = ch_out_ready;
      if (stall_mode) ch_in_ready[3] = 1'b1;
   end

   always @(posedge clock) begin
      if (!stall_mode) emitted <= 0;
      else if (ch_out_valid[3] && ch_out_ready[3]) emitted <= emitted + 1;
   end

   task automatic idle_inputs();
      in_valid     = 1'b0;
      in_data      = '0;
      in_last      = 1'b0;
      out_ready    = 1'b0;
      result_ready = 1'b0;
   endtask

   // Waits for the report (expected the cycle right after completion),
   // holds result_ready low for 'hold' cycles checking stability, then
   // completes the handshake. Returns just after that posedge.
   task automatic collect_result(input logic [1:0] es, input logic [CW-1:0] ec,
                                 input int hold, input string tag);
      int waited;
      waited = 0;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clock);
      while (!result_valid && waited < 4) begin
         @(posedge clock); #1;
         @(negedge clock);
         waited++;
      end
      total++;
      if (!result_valid || waited != 0)
         $display("FAIL %s result_latency: valid=%0b waited=%0d required valid=1 waited=0",
                  tag, result_valid, waited);
      else passed++;
      for (int i = 0; i <= hold; i++) begin
         if (i > 0) @(negedge clock);
         total++;
         if (result_valid !== 1'b1 || result_status !== es || result_cycles !== ec || in_ready !== 1'b0)
            $display("FAIL %s result[%0d]: valid=%0b status=%0d cycles=%0d in_ready=%0b required 1/%0d/%0d/0",
                     tag, i, result_valid, result_status, result_cycles, in_ready, es, ec);
         else passed++;
         result_ready = (i == hold);
         @(posedge clock); #1;
      end
      result_ready = 1'b0;
   endtask

   // Drives one packet: header 'ch', n payload beats. rnd adds random
   // ingress gaps and egress back-pressure (never two idle cycles in a row).
   task automatic run_packet(input int ch, input int n, input bit rnd,
                             input int hold, input string tag);
      logic [DW-1:0] payload [8];
      logic [CH-1:0] exp_en;
      logic [1:0]    es;
      int            ec;
      int            idx;
      int            cyc;
      bit            v, r, prev;
      for (int i = 0; i < 8; i++) payload[i] = DW'($urandom_range(0, 255));
      if (tag == "basic") begin
         payload[0] = "a";
         payload[1] = "b";
      end

      in_valid  = 1'b1;
      in_data   = DW'(ch);
      in_last   = (n == 0);
      out_ready = 1'b1;
      @(negedge clock);
      total++;
      if (in_ready !== 1'b1 || result_valid !== 1'b0)
         $display("FAIL %s header_accept: in_ready=%0b result_valid=%0b required 1/0",
                  tag, in_ready, result_valid);
      else passed++;
      @(posedge clock); #1;

      ec  = 0;
      idx = 0;
      if (ch >= CH) es = 2'd1;
      else if (n == 0) es = 2'd2;
      else es = 2'd0;

      if (n > 0 && ch >= CH) begin
         cyc = 0;
         while (idx < n && cyc < 40) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            in_data  = payload[idx];
            in_last  = (idx == n - 1);
            @(negedge clock);
            total++;
            if (in_ready !== 1'b1 || ch_in_valid !== '0 || ch_enable !== '0 || out_valid !== 1'b0)
               $display("FAIL %s drain[%0d]: in_ready=%0b ch_in_valid=%0h ch_enable=%0h out_valid=%0b required 1/0/0/0",
                        tag, cyc, in_ready, ch_in_valid, ch_enable, out_valid);
            else passed++;
            @(posedge clock); #1;
            if (v) idx++;
            cyc++;
         end
      end else if (n > 0) begin
         exp_en = '0;
         exp_en[ch] = 1'b1;
         cyc  = 0;
         prev = 1'b1;
         while (idx < n && cyc < 40) begin
            v = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            r = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!prev) begin v = 1'b1; r = 1'b1; end
            in_valid  = v;
            in_data   = payload[idx];
            in_last   = (idx == n - 1);
            out_ready = r;
            @(negedge clock);
            total++;
            if (ch_enable !== exp_en || in_ready !== r || out_valid !== v)
               $display("FAIL %s fwd_ctl[%0d]: en=%0h in_ready=%0b out_valid=%0b required %0h/%0b/%0b",
                        tag, cyc, ch_enable, in_ready, out_valid, exp_en, r, v);
            else passed++;
            if (v) begin
               total++;
               if (out_data !== payload[idx] || out_last !== (idx == n - 1))
                  $display("FAIL %s fwd_data[%0d]: data=%0h last=%0b required %0h/%0b",
                           tag, idx, out_data, out_last, payload[idx], (idx == n - 1));
               else passed++;
            end
            @(posedge clock); #1;
            cyc++;
            prev = v && r;
            if (prev) idx++;
         end
         // Cycles run from the first FORWARD cycle through the one that
         // carried the final beat both ways.
         ec = cyc;
      end
      out_ready = 1'b0;
      collect_result(es, CW'(ec), hold, tag);
   endtask

   task automatic test_reset();
      logic [93:0] all_out;
      idle_inputs();
      reset    = 1'b1;
      in_valid = 1'b1;
      out_ready = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      @(negedge clock);
      all_out = {in_ready, ch_in_data, ch_in_valid, ch_in_last, ch_enable, ch_out_ready,
                 out_data, out_valid, out_last, result_cycles, result_status, result_valid};
      total++;
      if (all_out !== '0) $display("FAIL reset_outputs: outputs=%0h required 0", all_out);
      else passed++;
      idle_inputs();
      reset = 1'b0;
      @(posedge clock); #1;
      @(negedge clock);
      total++;
      if (in_ready !== 1'b1 || result_valid !== 1'b0)
         $display("FAIL reset_idle: in_ready=%0b result_valid=%0b required 1/0", in_ready, result_valid);
      else passed++;
      @(posedge clock); #1;
   endtask

   task automatic test_basic();
      run_packet(2, 2, 1'b0, 0, "basic");
   endtask

   task automatic test_bad_channel();
      run_packet(5, 3, 1'b0, 0, "bad_channel");
      run_packet(7, 0, 1'b0, 0, "bad_channel_hdr_last");
   endtask

   task automatic test_empty();
      in_valid = 1'b1;
      in_data  = 8'h01;
      in_last  = 1'b1;
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      @(negedge clock);
      total++;
      if (ch_enable !== '0) $display("FAIL empty_enable: ch_enable=%0h required 0", ch_enable);
      else passed++;
      collect_result(2'd2, '0, 0, "empty");
   endtask

   task automatic test_timeout();
      logic [DW-1:0] beats [3];
      int  idx;
      int  fcyc;
      bit  seen;
      bit  acc;
      beats[0] = 8'h5a;
      beats[1] = 8'h3c;
      beats[2] = 8'hc3;
      stall_mode = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h03;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      idx  = 0;
      seen = 1'b0;
      fcyc = -1;
      for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
         in_valid = (idx < 3);
         in_data  = (idx < 3) ? beats[idx] : '0;
         in_last  = (idx == 2);
         @(negedge clock);
         acc = in_valid && in_ready;
         if (cyc == 0) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== beats[0] || out_last !== 1'b0)
               $display("FAIL timeout_first_beat: valid=%0b data=%0h last=%0b required 1/%0h/0",
                        out_valid, out_data, out_last, beats[0]);
            else passed++;
         end
         if (out_valid && out_last) begin
            seen = 1'b1;
            fcyc = cyc;
            total++;
            if (out_data !== '0 || ch_enable !== '0)
               $display("FAIL timeout_forced_beat: data=%0h ch_enable=%0h required 0/0", out_data, ch_enable);
            else passed++;
         end
         @(posedge clock); #1;
         if (acc) idx++;
      end
      total++;
      if (!seen || fcyc != TO)
         $display("FAIL timeout_forced_cycle: seen=%0b cycle=%0d required 1/%0d", seen, fcyc, TO);
      else passed++;
      out_ready = 1'b0;
      collect_result(2'd3, CW'(TO), 0, "timeout");
      stall_mode = 1'b0;
      run_packet(0, 3, 1'b0, 0, "after_timeout");
   endtask

   task automatic test_result_hold();
      run_packet(1, 2, 1'b0, 10, "hold");
      run_packet(3, 1, 1'b0, 0, "hold_next");
   endtask

   task automatic test_reset_mid();
      logic [93:0] all_out;
      in_valid  = 1'b1;
      in_data   = 8'h01;
      in_last   = 1'b0;
      out_ready = 1'b1;
      @(posedge clock); #1;
      in_data = 8'h77;
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      @(negedge clock);
      all_out = {in_ready, ch_in_data, ch_in_valid, ch_in_last, ch_enable, ch_out_ready,
                 out_data, out_valid, out_last, result_cycles, result_status, result_valid};
      total++;
      if (all_out !== '0) $display("FAIL reset_mid_outputs: outputs=%0h required 0", all_out);
      else passed++;
      idle_inputs();
      reset = 1'b0;
      @(posedge clock); #1;
      run_packet(1, 4, 1'b0, 0, "after_reset");
   endtask

   task automatic test_random();
      for (int p = 0; p < 25; p++) begin
         run_packet($urandom_range(0, 5), $urandom_range(0, 4), 1'b1,
                    $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      total      = 0;
      passed     = 0;
      stall_mode = 1'b0;
      reset      = 1'b1;
      idle_inputs();
      test_reset();
      test_basic();
      test_bad_channel();
      test_empty();
      test_timeout();
      test_result_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/multi_channel_processor_controller.md
Name: multi_channel_processor_controller

Overview:
Successor to the single-processor controller in the test harness. It sits between the parsed-packet FIFO and the packet constructor, and serves CHANNELS processors instead of one.
- First byte of each packet is a header that selects the target channel.
- Payload is forwarded to the selected processor, and that processor's output is returned on egress.
- Elapsed cycles and a status code are reported per packet.
- Adds bad-channel rejection, empty-packet handling, a timeout with a forced terminating beat, and a saturating counter.

Parameters:
DATA_WIDTH, 8, payload beat width
CHANNELS, 4, number of processors (1..256)
COUNTER_WIDTH, 32, width of the cycle count
TIMEOUT_CYCLES, 0, abort threshold in cycles after header; 0 disables the timeout

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
in_data  in  DATA_WIDTH  ingress beat (header or payload)
in_valid  in  1  ingress valid
in_ready  out  1  ingress ready
in_last  in  1  final beat of the packet
ch_in_data  out  CHANNELS*DATA_WIDTH  payload to processors; channel k occupies slice k
ch_in_valid  out  CHANNELS  per-channel valid
ch_in_ready  in  CHANNELS  per-channel ready
ch_in_last  out  CHANNELS  per-channel last
ch_enable  out  CHANNELS  processor enable, one-hot or zero
ch_out_data  in  CHANNELS*DATA_WIDTH  processor results
ch_out_valid  in  CHANNELS  per-channel result valid
ch_out_ready  out  CHANNELS  per-channel result ready
ch_out_last  in  CHANNELS  per-channel result last
out_data  out  DATA_WIDTH  egress beat
out_valid  out  1  egress valid
out_ready  in  1  egress ready
out_last  out  1  egress last
result_cycles  out  COUNTER_WIDTH  elapsed cycles for the packet
result_status  out  2  packet status code
result_valid  out  1  result valid
result_ready  in  1  result ready

Behaviour:
- Reset (also mid-packet): state returns to IDLE and all flags and the counter clear. All outputs read 0, including ch_enable, in_ready and result_valid. Any partial packet is abandoned; the bench restarts clean.
- States: IDLE, FORWARD, DRAIN, TERMINATE, REPORT.
- IDLE:
  - in_ready=1.
  - Header accepted: sel <= in_data, counter <= 0, in_done <= in_last, out_done <= 0.
  - If in_data >= CHANNELS: go to REPORT (status BAD_CHANNEL) when in_last is set, otherwise to DRAIN.
  - Else if in_last: go to REPORT, status EMPTY, cycles 0.
  - Else: go to FORWARD.
- FORWARD:
  - ch_enable[sel]=1.
  - Ingress is passed combinationally to slice sel; ch_in_valid[sel] = in_valid & !in_done; in_ready = ch_in_ready[sel] & !in_done.
  - Egress: out_* = ch_out_*[sel] and ch_out_ready[sel] = out_ready, gated by !out_done.
  - Unselected channels see valid=0 and ready=0.
  - Accepted in_last sets in_done. Accepted egress last sets out_done. Either may come first.
  - Counter increments every cycle and saturates at all-ones; no wrap.
  - When in_done and out_done are both true (including set in the same cycle): result_cycles <= counter value of that cycle + 1 (saturating), status OK, go to REPORT.
  - Timeout: TIMEOUT_CYCLES != 0, counter+1 == TIMEOUT_CYCLES, and not both done.
    - ch_enable drops the next cycle.
    - If egress has emitted at least one beat and !out_done, go to TERMINATE; otherwise go to DRAIN if !in_done, else to REPORT.
    - Status is TIMEOUT and cycles = TIMEOUT_CYCLES.
- TERMINATE:
  - Drives out_data=0, out_last=1, out_valid=1 and holds until out_ready.
  - Then goes to DRAIN if !in_done, else to REPORT.
- DRAIN:
  - in_ready=1; beats are discarded and never reach a processor.
  - Exits to REPORT on the accepted in_last.
- REPORT:
  - result_valid=1 with stable cycles and status; in_ready=0.
  - Goes to IDLE on result_ready.
- One packet in flight at a time; no header is accepted until the result handshake completes.
- Status codes: OK=0, BAD_CHANNEL=1, EMPTY=2, TIMEOUT=3.
- Latency: combinational passthrough, zero added cycles per beat. One registered cycle from completion to result_valid.

Decomposition:
- Package harness_pkg holds the state enum and the STATUS_OK, STATUS_BAD_CHANNEL, STATUS_EMPTY and STATUS_TIMEOUT localparams, so packet_constructor can decode the status.
- One sub-module, saturating_cycle_counter: parameter WIDTH; ports clear, enable, count.

Test Plan:
- CHANNELS=4. Header 0x02, then payload 'a','b' (last); ch2 echoes both beats, last on the cycle its input last is accepted, no stalls -> only ch_enable[2] high; egress 'a','b' with last; result_status=0, result_cycles=2.
- Header 0x05 (out of range), 3 payload beats -> all three drained, no ch_in_valid ever; status=1, cycles=0.
- Header 0x01 with in_last=1 -> status=2, cycles=0; ch_enable stays 0.
- TIMEOUT_CYCLES=16; ch3 emits one beat then stalls -> forced beat out_data=0, out_last=1; status=3, cycles=16; next packet to ch0 completes with status OK.
- result_ready held low 10 cycles -> result stable and in_ready=0 throughout; next header accepted the cycle after the handshake.
- Reset asserted mid-payload -> next cycle all outputs 0 and state IDLE; a fresh packet completes normally.
